disp_scan_capture: RTL and testbench
====================================

// Module: disp_scan_capture
// PURPOSE
//  Receive side of the multiplexed 4-digit 7-segment scan bus: anodes plus one shared segment bus.
//  Samples the bus once per settled digit slot, decodes each glyph back to a hex nibble and
//  rebuilds the 4-digit word. Flags a complete frame, and flags illegal anode patterns and unknown glyphs.
//  Sits beside the display driver as an on-chip read-back/self-check monitor.
// PARAMETERS
//  SETTLE  2  cycles In_An must stay unchanged before the slot is sampled (>=1)
// PORTS
//  CLK         in   1   system clock, rising edge
//  Reset       in   1   asynchronous, active-high
//  In_An       in   4   anode enables, active-low; bit n = digit n
//  In_Seg      in   7   segments, active-low; [6:0] = g f e d c b a
//  Out_Digits  out  16  captured nibbles; digit n at [4n+3:4n]
//  Out_Mask    out  4   digits written since last frame; bit n = digit n
//  Out_Frame   out  1   1-cycle pulse: all 4 digits captured
//  Out_Err     out  1   1-cycle pulse: illegal anode pattern or unknown glyph
// BEHAVIOUR
//  Reset (async): Out_Digits=0, Out_Mask=0, Out_Frame=0, Out_Err=0.
//   Internal: r_An=4'b1111, r_Seg=7'h7F, cnt=0, state=S_SETTLE.
//  Input stage: r_An <= In_An and r_Seg <= In_Seg on every edge. Decode uses r_Seg only.
//  FSM (2 states):
//   - S_SETTLE: if In_An != r_An, cnt<=0. Otherwise cnt<=cnt+1.
//     On the edge where cnt==SETTLE-1 and In_An==r_An: act on r_An, then go to S_HOLD.
//   - S_HOLD: no action while In_An==r_An.
//     On In_An != r_An: go to S_SETTLE with cnt<=0.
//  Action (one per dwell), from r_An:
//   - 4'b1111 (blank): nothing, no error.
//   - Exactly one bit low (bit n): decode r_Seg.
//     Known glyph -> Out_Digits[4n+3:4n]<=nibble, Out_Mask[n]<=1.
//     Unknown glyph -> Out_Err=1 for 1 cycle; digit and mask unchanged.
//   - Two or more bits low: Out_Err=1 for 1 cycle; no write.
//  Glyph table (r_Seg, gfedcba) -> nibble:
//   0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000
//   8:0000000 9:0010000 A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110
//   Any other code is unknown.
//  Frame:
//   - A write that would make the mask 4'b1111 instead sets Out_Mask<=0 and Out_Frame=1
//     on the same edge. Out_Digits already holds the new nibble on that edge.
//   - A repeat write to a digit before the frame completes overwrites the nibble; mask bit stays 1.
//  Latency: In_An changes before edge E0. Out_Digits/Mask/Frame/Err update on edge E0+SETTLE.
//  Dwell shorter than SETTLE+1 cycles: never sampled, no error. cnt saturates at SETTLE.
//  In_Seg changing mid-dwell after the sample point: ignored until the next anode change.
//  Out_Frame and Out_Err can never both be 1 in the same cycle.
//  Reset mid-dwell: all state clears; capture restarts with a fresh settle count.
// TESTING
//  1 Scan An 1110/1101/1011/0111 with Seg for 1,2,3,4, 8 cycles each
//    -> Out_Digits=16'h4321; Out_Frame pulses once, on the 4th sample edge; Out_Mask back to 0.
//  2 An=1110 for only 2 cycles (SETTLE=2), then 1111
//    -> no write, Out_Mask=0, no Out_Err.
//  3 An=1100 held 5 cycles -> exactly one Out_Err pulse, 3 cycles after the change; Out_Digits unchanged.
//  4 An=1101, Seg=7'b1111111 (unknown) -> one Out_Err pulse; Out_Mask[1] stays 0.
//  5 Digit0 written with 5, then digit0 again with A before the other digits
//    -> Out_Digits[3:0]=A; Out_Mask=0001; no frame.
//  6 Assert Reset during the 3rd digit dwell -> all outputs 0 at once;
//    a full rescan then yields one Out_Frame.

Source files
------------

// File: rtl/disp_scan_capture.sv
// Read-back monitor for a multiplexed 4-digit 7-segment scan bus: samples each settled
// digit slot, decodes the glyph to a hex nibble and rebuilds the displayed word.
module disp_scan_capture #(
    parameter int SETTLE = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [3:0]  In_An,
    input  logic [6:0]  In_Seg,
    output logic [15:0] Out_Digits,
    output logic [3:0]  Out_Mask,
    output logic        Out_Frame,
    output logic        Out_Err
);

    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE);

    typedef enum logic {S_SETTLE, S_HOLD} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic [3:0]    mask_q;
    logic          frame_q;
    logic          err_q;

    logic       glyph_ok;
    logic [3:0] glyph_nib;
    logic       one_low;
    logic       act;
    logic       wr_en;
    logic [3:0] mask_set;

    // Active-low segment codes, gfedcba order.
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_nib = 4'h0;
        case (seg_q)
            7'b1000000: glyph_nib = 4'h0;
            7'b1111001: glyph_nib = 4'h1;
            7'b0100100: glyph_nib = 4'h2;
            7'b0110000: glyph_nib = 4'h3;
            7'b0011001: glyph_nib = 4'h4;
            7'b0010010: glyph_nib = 4'h5;
            7'b0000010: glyph_nib = 4'h6;
            7'b1111000: glyph_nib = 4'h7;
            7'b0000000: glyph_nib = 4'h8;
            7'b0010000: glyph_nib = 4'h9;
            7'b0001000: glyph_nib = 4'hA;
            7'b0000011: glyph_nib = 4'hB;
            7'b1000110: glyph_nib = 4'hC;
            7'b0100001: glyph_nib = 4'hD;
            7'b0000110: glyph_nib = 4'hE;
            7'b0001110: glyph_nib = 4'hF;
            default:    glyph_ok  = 1'b0;
        endcase
    end

    always_comb begin
        one_low  = $onehot(~an_q);
        act      = (state_q == S_SETTLE) && (In_An == an_q) && (cnt_q == CNT_LAST);
        wr_en    = act && one_low && glyph_ok;
        mask_set = mask_q | ~an_q;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_SETTLE;
            cnt_q   <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            mask_q  <= 4'b0000;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            an_q    <= In_An;
            seg_q   <= In_Seg;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_SETTLE: begin
                    if (In_An != an_q) begin
                        cnt_q <= '0;
                    end else begin
                        if (cnt_q != CNT_MAX)
                            cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_HOLD;
                            if (one_low) begin
                                if (glyph_ok) begin
                                    // Completing the set closes the frame instead of showing 1111.
                                    if (mask_set == 4'b1111) begin
                                        mask_q  <= 4'b0000;
                                        frame_q <= 1'b1;
                                    end else begin
                                        mask_q <= mask_set;
                                    end
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end else if (an_q != 4'b1111) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (In_An != an_q) begin
                        state_q <= S_SETTLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= S_SETTLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [3:0] digit_q;

        always_ff @(posedge CLK or posedge Reset) begin
            if (Reset)
                digit_q <= 4'h0;
            else if (wr_en && !an_q[gi])
                digit_q <= glyph_nib;
        end

        assign Out_Digits[4*gi +: 4] = digit_q;
    end

    assign Out_Mask  = mask_q;
    assign Out_Frame = frame_q;
    assign Out_Err   = err_q;

endmodule

// File: tb/tb_disp_scan_capture.sv
// Directed and random scan sequences checked against a dwell-length reference model.
module tb_disp_scan_capture;

    localparam int SETTLE = 2;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        CLK = 1'b0;
    logic        Reset;
    logic [3:0]  In_An;
    logic [6:0]  In_Seg;
    logic [15:0] Out_Digits;
    logic [3:0]  Out_Mask;
    logic        Out_Frame;
    logic        Out_Err;

    disp_scan_capture #(.SETTLE(SETTLE)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .In_An      (In_An),
        .In_Seg     (In_Seg),
        .Out_Digits (Out_Digits),
        .Out_Mask   (Out_Mask),
        .Out_Frame  (Out_Frame),
        .Out_Err    (Out_Err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int n_frames = 0;
    int n_errs   = 0;

    // Reference model: a slot is sampled on the edge where In_An has been identical
    // for exactly SETTLE+1 consecutive edges, using the segments seen one edge earlier.
    logic [3:0] m_dig [4];
    logic [3:0] m_mask;
    logic       m_frame, m_err;
    logic [3:0] m_prev_an;
    logic [6:0] m_prev_seg;
    int         m_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_mask = 4'h0; m_frame = 1'b0; m_err = 1'b0;
        m_prev_an = 4'b1111; m_prev_seg = 7'h7F; m_run = 1;
    endtask

    task automatic mdl_act(input logic [3:0] an, input logic [6:0] seg);
        int  lows, n, nib;
        bit  found;
        lows = $countones(~an);
        n = 0; nib = 0; found = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) n = i;
        for (int i = 0; i < 16; i++) if (GLYPH[i] == seg) begin nib = i; found = 1; end
        if (lows >= 2) begin
            m_err = 1'b1;
        end else if (lows == 1) begin
            if (!found) begin
                m_err = 1'b1;
            end else begin
                m_dig[n] = 4'(nib);
                if ((m_mask | (4'b1 << n)) == 4'hF) begin
                    m_mask = 4'h0; m_frame = 1'b1;
                end else begin
                    m_mask = m_mask | (4'b1 << n);
                end
            end
        end
    endtask

    task automatic mdl_edge(input logic [3:0] an, input logic [6:0] seg);
        m_frame = 1'b0; m_err = 1'b0;
        if (an == m_prev_an) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        if (m_run == SETTLE + 1) mdl_act(an, m_prev_seg);
        m_prev_an = an; m_prev_seg = seg;
    endtask

    task automatic check_outputs();
        check("digits", 32'(Out_Digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
        check("mask",   32'(Out_Mask),  32'(m_mask));
        check("frame",  32'(Out_Frame), 32'(m_frame));
        check("err",    32'(Out_Err),   32'(m_err));
        if (Out_Frame === 1'b1) n_frames++;
        if (Out_Err === 1'b1)   n_errs++;
    endtask

    // Drive one dwell from just after a falling edge; check each cycle on the next falling edge.
    task automatic step(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            In_An = an; In_Seg = seg;
            @(posedge CLK);
            mdl_edge(an, seg);
            @(negedge CLK);
            check_outputs();
        end
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        In_An = 4'b1111; In_Seg = 7'h7F;
        mdl_reset();
        #1;
        check_outputs();
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        int f0, e0;
        logic [3:0] an;
        logic [6:0] seg;
        int dwell;

        Reset = 1'b1; In_An = 4'b1111; In_Seg = 7'h7F;
        mdl_reset();
        @(negedge CLK);
        check_outputs();
        @(negedge CLK);
        Reset = 1'b0;

        // Full scan 1-2-3-4
        f0 = n_frames;
        step(4'b1110, GLYPH[1], 8);
        step(4'b1101, GLYPH[2], 8);
        step(4'b1011, GLYPH[3], 8);
        step(4'b0111, GLYPH[4], 8);
        check("scan_frames", 32'(n_frames - f0), 32'd1);
        check("scan_word",   32'(Out_Digits), 32'h4321);
        check("scan_mask",   32'(Out_Mask), 32'h0);

        // Dwell too short to be sampled
        e0 = n_errs;
        step(4'b1110, GLYPH[7], 2);
        step(4'b1111, 7'h7F, 4);
        check("short_mask", 32'(Out_Mask), 32'h0);
        check("short_err",  32'(n_errs - e0), 32'd0);

        // Two anodes low
        e0 = n_errs;
        step(4'b1100, GLYPH[5], 5);
        check("multi_err",  32'(n_errs - e0), 32'd1);
        check("multi_word", 32'(Out_Digits), 32'h4321);
        step(4'b1111, 7'h7F, 3);

        // Unknown glyph
        e0 = n_errs;
        step(4'b1101, 7'b1111111, 5);
        check("unk_err",  32'(n_errs - e0), 32'd1);
        check("unk_mask", 32'(Out_Mask[1]), 32'd0);
        step(4'b1111, 7'h7F, 3);

        // Overwrite of digit 0 before frame completes
        f0 = n_frames;
        step(4'b1110, GLYPH[5], 4);
        step(4'b1111, 7'h7F, 2);
        step(4'b1110, GLYPH[10], 4);
        check("ovr_nib",    32'(Out_Digits[3:0]), 32'hA);
        check("ovr_mask",   32'(Out_Mask), 32'b0001);
        check("ovr_frames", 32'(n_frames - f0), 32'd0);
        step(4'b1111, 7'h7F, 2);

        // Reset during the third digit dwell, then rescan
        step(4'b1110, GLYPH[6], 8);
        step(4'b1101, GLYPH[7], 8);
        step(4'b1011, GLYPH[8], 2);
        pulse_reset();
        check("rst_word", 32'(Out_Digits), 32'h0);
        check("rst_mask", 32'(Out_Mask), 32'h0);
        f0 = n_frames;
        step(4'b1110, GLYPH[9], 8);
        step(4'b1101, GLYPH[11], 8);
        step(4'b1011, GLYPH[12], 8);
        step(4'b0111, GLYPH[13], 8);
        check("rescan_frames", 32'(n_frames - f0), 32'd1);
        check("rescan_word",   32'(Out_Digits), 32'hDCB9);

        // Random dwells with occasional mid-dwell segment changes and illegal codes
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       an = 4'b1111;
                8, 9:    an = 4'($urandom);
                default: an = ~(4'b1 << $urandom_range(0, 3));
            endcase
            dwell = $urandom_range(1, 6);
            for (int c = 0; c < dwell; c++) begin
                if (c == 0 || $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 7) == 0) seg = 7'($urandom);
                    else                           seg = GLYPH[$urandom_range(0, 15)];
                end
                step(an, seg, 1);
            end
            if (k == 150) pulse_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
